// File: rtl/ysyx_25030085_pkg.sv
// Shared constants and types for the ysyx_25030085 core frontend and decode.
package ysyx_25030085_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch FSM encoding (3-bit)
    typedef enum logic [2:0] {
        FS_REQ      = 3'd0,
        FS_WAIT_RSP = 3'd1,
        FS_HOLD     = 3'd2,
        FS_WAIT_NPC = 3'd3,
        FS_ERR      = 3'd4
    } fetch_state_e;

    // RV32I major opcodes used by decode
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Word alignment test for instruction addresses
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_25030085_pc_reg.sv
// Program counter register with load enable and reset value; reusable by a pipelined frontend.
module ysyx_25030085_pc_reg #(
    parameter int unsigned     W       = 32,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pc_q;

    // Load on enable, synchronous reset to RST_VAL
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_VAL;
        end else if (en_i) begin
            pc_q <= din_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/ysyx_25030085_ifu_fetch.sv
// Non-pipelined instruction fetch: one request per step, waits for the next PC from execute.
module ysyx_25030085_ifu_fetch #(
    parameter logic [31:0] RESET_PC  = ysyx_25030085_pkg::RESET_PC,
    parameter bit          ALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_err,
    input  logic        npc_valid,
    input  logic [31:0] npc
);

    import ysyx_25030085_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q;
    logic         pc_en;

    ysyx_25030085_pc_reg #(
        .W       (32),
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pc_en),
        .din_i (npc),
        .q_o   (pc_q)
    );

    // State and instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_REQ;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state logic; outputs decode from state and registered pc only
    always_comb begin
        state_d        = state_q;
        inst_d         = inst_q;
        pc_en          = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        fetch_err      = 1'b0;
        unique case (state_q)
            FS_REQ: begin
                if (ALIGN_CHK && !is_word_aligned(pc_q)) begin
                    state_d = FS_ERR;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        state_d = FS_WAIT_RSP;
                    end
                end
            end
            FS_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = FS_ERR;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    state_d = FS_WAIT_NPC;
                end
            end
            FS_WAIT_NPC: begin
                if (npc_valid) begin
                    pc_en   = 1'b1;
                    state_d = FS_REQ;
                end
            end
            FS_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                state_d = FS_ERR;
            end
        endcase
    end

    assign imem_req_addr = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;

endmodule

// File: tb/tb_ysyx_25030085_ifu_fetch.sv
// Scoreboard bench for the fetch unit: stimulus pushes expected {inst, pc}, a monitor pops on handshake.
module tb_ysyx_25030085_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_err;
    logic        npc_valid;
    logic [31:0] npc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned acc_cnt  = 0;
    logic [63:0] exp_q[$];

    ysyx_25030085_ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .fetch_err      (fetch_err),
        .npc_valid      (npc_valid),
        .npc            (npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count requests the memory side will accept on the coming edge
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) acc_cnt++;
    end

    // Monitor: compare every decode handshake against the scoreboard
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL mon_unexpected: got inst %h pc %h expected no transfer", inst, pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("mon_inst", inst, e[63:32]);
                chk("mon_pc", pc, e[31:0]);
            end
        end
    end

    // One fetch from REQ through decode handshake; leaves the DUT in WAIT_NPC
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_pc,
                            input int rdly, input int hdly, input bit npc_in_hold);
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_req_addr, exp_pc);
        for (int i = 0; i < rdly; i++) begin
            if (i == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hBAD0_0BAD;
            end
            step();
            imem_rsp_valid = 1'b0;
            chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("req_hold_addr", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("lat_wait_inst_valid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        imem_rsp_err   = 1'b0;
        exp_q.push_back({word, exp_pc});
        step();
        imem_rsp_valid = 1'b0;
        chk("lat_inst_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < hdly; i++) begin
            if (npc_in_hold && i == 0) begin
                npc_valid = 1'b1;
                npc       = 32'h9000_0000;
            end
            step();
            npc_valid = 1'b0;
            chk("hold_inst", inst, word);
            chk("hold_pc", pc, exp_pc);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wnpc_inst_valid", 32'(inst_valid), 32'd0);
        chk("wnpc_req_valid", 32'(imem_req_valid), 32'd0);
    endtask

    task automatic give_npc(input logic [31:0] v);
        npc_valid = 1'b1;
        npc       = v;
        step();
        npc_valid = 1'b0;
    endtask

    initial begin
        int unsigned a0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc_valid      = 1'b0;
        npc            = '0;

        // Reset held three cycles
        step(); step(); step();
        rst = 1'b0;
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_addr", imem_req_addr, 32'h8000_0000);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);

        // Zero-wait fetch then sequential next PC
        do_fetch(32'h0010_0093, 32'h8000_0000, 0, 0, 1'b0);
        give_npc(32'h8000_0004);

        // Backpressure on both sides, one accepted request
        a0 = acc_cnt;
        do_fetch(32'h0020_8113, 32'h8000_0004, 5, 4, 1'b0);
        chk("one_accept", acc_cnt - a0, 32'd1);
        give_npc(32'h8000_0100);

        // Jump target; npc pulse during HOLD ignored
        do_fetch(32'h0000_006F, 32'h8000_0100, 1, 2, 1'b1);
        chk("jump_pc_kept", pc, 32'h8000_0100);

        // Misaligned next PC goes to ERR without a request
        give_npc(32'h8000_0002);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mis_pc", pc, 32'h8000_0002);
        step();
        chk("mis_fetch_err", 32'(fetch_err), 32'd1);
        chk("mis_inst_valid", 32'(inst_valid), 32'd0);
        a0 = acc_cnt;
        imem_req_ready = 1'b1;
        step(); step();
        imem_req_ready = 1'b0;
        chk("err_no_accept", acc_cnt - a0, 32'd0);
        chk("err_sticky", 32'(fetch_err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_clr", 32'(fetch_err), 32'd0);

        // Bus error on response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        step();
        chk("buserr_fetch_err", 32'(fetch_err), 32'd1);
        chk("buserr_inst_valid", 32'(inst_valid), 32'd0);
        chk("buserr_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Move pc away from reset value, then reset in WAIT_RSP
        do_fetch(32'h0030_0193, 32'h8000_0000, 0, 0, 1'b0);
        give_npc(32'h8000_0040);
        chk("pre_rst_addr", imem_req_addr, 32'h8000_0040);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rstw_pc", pc, 32'h8000_0000);
        chk("rstw_inst_valid", 32'(inst_valid), 32'd0);

        // Reset in HOLD
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        chk("rsth_pre_valid", 32'(inst_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsth_inst_valid", 32'(inst_valid), 32'd0);
        chk("rsth_pc", pc, 32'h8000_0000);
        chk("rsth_inst", inst, 32'h0000_0013);
        chk("rsth_req_valid", 32'(imem_req_valid), 32'd1);

        // Recovery fetch after reset
        do_fetch(32'h0040_0213, 32'h8000_0000, 0, 1, 1'b0);
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
